// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
// Holds the opcodes, the datapath width, the FSM states and the legal-op check.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_SLTU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_SLTU;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: ADD/AND/OR/MUL16/SUB/SLTU.
// Ports: op, a, b in; res (result), illegal (opcode 6/7) out.
module alu_core
   import alu_pkg::*;
(
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] res,
   output logic              illegal
);

   always_comb begin
      res     = '0;
      illegal = 1'b0;
      case (op)
         OP_ADD:  res = a + b;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_MUL:  res = {16'd0, a[15:0]} * {16'd0, b[15:0]};
         OP_SUB:  res = a - b;
         OP_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among N_REQ requesters.
// Ports: clk, rst_n, req/op_flat/a_flat/b_flat in; gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy out.
module alu_rr_scheduler
   import alu_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int MUL_LAT = 3,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [3*N_REQ-1:0]      op_flat,
   input  logic [DATA_W*N_REQ-1:0] a_flat,
   input  logic [DATA_W*N_REQ-1:0] b_flat,
   output logic [N_REQ-1:0]        gnt,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_err,
   output logic                    busy
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                err_q, err_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic                busy_q, busy_d;

   logic                found;
   logic [ID_W-1:0]     pick_idx;
   logic [ID_W:0]       cand_w;
   logic [ID_W-1:0]     cand;
   logic [2:0]          sel_op;
   logic [DATA_W-1:0]   sel_a;
   logic [DATA_W-1:0]   sel_b;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_illegal;

   alu_core u_alu (
      .op      (op_q),
      .a       (a_q),
      .b       (b_q),
      .res     (alu_res),
      .illegal (alu_illegal)
   );

   // First requester at or above rr_ptr, wrapping at N_REQ.
   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      cand_w   = '0;
      cand     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand_w = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (cand_w >= (ID_W+1)'(N_REQ)) begin
            cand_w = cand_w - (ID_W+1)'(N_REQ);
         end
         cand = cand_w[ID_W-1:0];
         if (!found && req[cand]) begin
            found    = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == ID_W'(i)) begin
            sel_op = op_flat[3*i +: 3];
            sel_a  = a_flat[DATA_W*i +: DATA_W];
            sel_b  = b_flat[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      res_d       = res_q;
      err_d       = err_q;
      gnt_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      // busy lags the state by one cycle, like every other output
      busy_d      = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               gnt_d[pick_idx] = 1'b1;
               op_d = sel_op;
               a_d  = sel_a;
               b_d  = sel_b;
               id_d = pick_idx;
               if (pick_idx == ID_W'(N_REQ-1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = pick_idx + 1'b1;
               end
               if (op_legal(sel_op)) begin
                  cnt_d = (sel_op == OP_MUL) ?
                          CNT_W'(MUL_LAT-1) : '0;
                  state_d = ST_EXEC;
               end else begin
                  res_d   = '0;
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               res_d   = alu_res;
               err_d   = alu_illegal;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_data_d  = res_q;
            rsp_err_d   = err_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         res_q       <= '0;
         err_q       <= 1'b0;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         res_q       <= res_d;
         err_q       <= err_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: directed table, fairness, reset and random traffic.
// Random traffic is checked against a cycle-level reference model of the scheduler.
module tb_alu_rr_scheduler;

   localparam int N_REQ   = 4;
   localparam int MUL_LAT = 3;
   localparam int ID_W    = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [N_REQ-1:0]     req = '0;
   logic [3*N_REQ-1:0]   op_flat = '0;
   logic [32*N_REQ-1:0]  a_flat = '0;
   logic [32*N_REQ-1:0]  b_flat = '0;
   logic [N_REQ-1:0]     gnt;
   logic                 rsp_valid;
   logic [ID_W-1:0]      rsp_id;
   logic [31:0]          rsp_data;
   logic                 rsp_err;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   alu_rr_scheduler #(
      .N_REQ   (N_REQ),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .op_flat   (op_flat),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input int op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         0: return a + b;
         1: return a & b;
         2: return a | b;
         3: return (a % 32'h10000) * (b % 32'h10000);
         4: return a - b;
         5: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input int op);
      if (op > 5) return 1;
      if (op == 3) return MUL_LAT + 1;
      return 2;
   endfunction

   task automatic set_slot(input int i, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
      op_flat[3*i +: 3] = op;
      a_flat[32*i +: 32] = a;
      b_flat[32*i +: 32] = b;
   endtask

   task automatic do_reset();
      req = '0;
      rst_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_op(input int i, input vec_t v, input string nm);
      int n;
      int t0;
      int busy_bad;
      set_slot(i, v.op, v.a, v.b);
      req = N_REQ'(1) << i;
      n = 0;
      while (gnt == '0 && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("%s_gnt", nm), 32'(gnt), 32'd1 << i);
      chk($sformatf("%s_busy_T", nm), 32'(busy), 32'd0);
      req = '0;
      t0 = cyc;
      busy_bad = 0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
         if (!busy) busy_bad++;
      end
      chk($sformatf("%s_lat", nm), 32'(cyc - t0), 32'(v.exp_lat));
      chk($sformatf("%s_data", nm), rsp_data, v.exp_data);
      chk($sformatf("%s_err", nm), 32'(rsp_err), 32'(v.exp_err));
      chk($sformatf("%s_id", nm), 32'(rsp_id), 32'(i));
      chk($sformatf("%s_busy", nm), 32'(busy_bad), 32'd0);
   endtask

   initial begin
      vec_t tbl[14];
      int g_ids[$];
      int g_cyc[$];
      int r_ids[$];
      int vcount;
      int m_idle;
      int m_ptr;
      int e_gnt_at;
      int e_rsp_at;
      logic [31:0] e_mask;
      int e_id;
      logic [31:0] e_data;
      logic e_err;
      bit pend[N_REQ];
      logic [2:0] p_op[N_REQ];
      logic [31:0] p_a[N_REQ];
      logic [31:0] p_b[N_REQ];

      tbl[0]  = '{3'd0, 32'd5, 32'd3, 32'd8, 1'b0, 2};
      tbl[1]  = '{3'd1, 32'd5, 32'd3, 32'd1, 1'b0, 2};
      tbl[2]  = '{3'd2, 32'd5, 32'd3, 32'd7, 1'b0, 2};
      tbl[3]  = '{3'd3, 32'd5, 32'd3, 32'd15, 1'b0, 4};
      tbl[4]  = '{3'd4, 32'd5, 32'd3, 32'd2, 1'b0, 2};
      tbl[5]  = '{3'd5, 32'd5, 32'd3, 32'd0, 1'b0, 2};
      tbl[6]  = '{3'd4, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 2};
      tbl[7]  = '{3'd5, 32'd3, 32'd5, 32'd1, 1'b0, 2};
      tbl[8]  = '{3'd3, 32'h0001FFFF, 32'd2, 32'h0001FFFE, 1'b0, 4};
      tbl[9]  = '{3'd6, 32'd5, 32'd3, 32'd0, 1'b1, 1};
      tbl[10] = '{3'd0, 32'd1, 32'd1, 32'd2, 1'b0, 2};
      tbl[11] = '{3'd7, 32'd9, 32'd9, 32'd0, 1'b1, 1};
      tbl[12] = '{3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2};
      tbl[13] = '{3'd3, 32'h1234FFFF, 32'hABCDFFFF,
                  32'hFFFE0001, 1'b0, 4};

      // reset state
      rst_n = 1'b0;
      #2;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", rsp_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      do_reset();

      for (int k = 0; k < 14; k++) begin
         run_op(k % N_REQ, tbl[k], $sformatf("vec%0d", k));
      end

      // fairness: all four hold ADD requests
      do_reset();
      for (int i = 0; i < N_REQ; i++) begin
         set_slot(i, 3'd0, 32'(i * 10), 32'd1);
      end
      req = '1;
      for (int n = 0; n < 40 && r_ids.size() < 5; n++) begin
         tick();
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
               g_ids.push_back(i);
               g_cyc.push_back(cyc);
            end
         end
         if (rsp_valid) r_ids.push_back(int'(rsp_id));
      end
      req = '0;
      chk("rr_gnt_count", 32'(g_ids.size()), 32'd5);
      chk("rr_rsp_count", 32'(r_ids.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < g_ids.size()) begin
            chk($sformatf("rr_gnt%0d", k), 32'(g_ids[k]), 32'(k % 4));
         end
         if (k > 0 && k < g_cyc.size()) begin
            chk($sformatf("rr_gap%0d", k),
                32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
         end
         if (k < r_ids.size()) begin
            chk($sformatf("rr_rsp%0d", k), 32'(r_ids[k]), 32'(k % 4));
         end
      end
      tick();
      tick();
      tick();

      // reset while a MUL is executing
      set_slot(0, 3'd3, 32'd7, 32'd7);
      req = 4'b0001;
      for (int n = 0; n < 20 && gnt == '0; n++) tick();
      chk("mr_gnt", 32'(gnt), 32'd1);
      req = '0;
      tick();
      chk("mr_busy_pre", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_gnt0", 32'(gnt), 32'd0);
      chk("mr_valid0", 32'(rsp_valid), 32'd0);
      chk("mr_id0", 32'(rsp_id), 32'd0);
      chk("mr_data0", rsp_data, 32'd0);
      chk("mr_err0", 32'(rsp_err), 32'd0);
      chk("mr_busy0", 32'(busy), 32'd0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      vcount = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (rsp_valid) vcount++;
      end
      chk("mr_no_rsp", 32'(vcount), 32'd0);
      set_slot(1, 3'd0, 32'd1, 32'd2);
      set_slot(2, 3'd0, 32'd3, 32'd4);
      req = 4'b0110;
      for (int n = 0; n < 20 && gnt == '0; n++) tick();
      chk("mr_first_gnt", 32'(gnt), 32'b0010);
      req = '0;

      // random traffic against the reference model
      do_reset();
      m_idle = cyc;
      m_ptr = 0;
      e_gnt_at = -10;
      e_rsp_at = -10;
      e_mask = '0;
      e_id = 0;
      e_data = '0;
      e_err = 1'b0;
      for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         chk("rnd_gnt", 32'(gnt), (cyc == e_gnt_at) ? e_mask : 32'd0);
         chk("rnd_valid", 32'(rsp_valid), 32'(cyc == e_rsp_at));
         chk("rnd_busy", 32'(busy),
             32'(cyc > e_gnt_at && cyc <= e_rsp_at));
         if (cyc == e_rsp_at && rsp_valid) begin
            chk("rnd_id", 32'(rsp_id), 32'(e_id));
            chk("rnd_data", rsp_data, e_data);
            chk("rnd_err", 32'(rsp_err), 32'(e_err));
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (pend[i]) begin
               if ($urandom_range(0, 19) == 0) pend[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               p_op[i] = 3'($urandom_range(0, 7));
               p_a[i] = $urandom_range(0, 1) ? $urandom
                                               : $urandom_range(0, 15);
               p_b[i] = $urandom_range(0, 1) ? $urandom
                                               : $urandom_range(0, 15);
            end
            req[i] = pend[i];
            if (pend[i]) set_slot(i, p_op[i], p_a[i], p_b[i]);
         end
         if (cyc >= m_idle && req != '0) begin
            int k;
            k = -1;
            for (int j = 0; j < N_REQ; j++) begin
               if (k < 0 && req[(m_ptr + j) % N_REQ]) k = (m_ptr + j) % N_REQ;
            end
            e_gnt_at = cyc + 1;
            e_mask = 32'd1 << k;
            e_rsp_at = cyc + 1 + ref_lat(int'(p_op[k]));
            e_id = k;
            e_data = ref_alu(int'(p_op[k]), p_a[k], p_b[k]);
            e_err = (p_op[k] > 3'd5);
            m_idle = e_rsp_at;
            m_ptr = (k + 1) % N_REQ;
            pend[k] = 1'b0;
         end
         tick();
      end
      req = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
